// File: rtl/matrix_commutator.sv
// Four-step current-direction commutation for an N_OUT-phase matrix converter.
// It adds a per-phase dwell counter, a clearable clamp-fault latch, busy flags and a status LED.
module matrix_commutator #(
  parameter int N_OUT       = 3,
  parameter int STEP_CYCLES = 400,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [2*N_OUT-1:0]   sel,
  input  logic [N_OUT-1:0]     dir,
  input  logic                 clamp_signal,
  input  logic                 fault_clr,
  output logic [6*N_OUT-1:0]   gate,
  output logic [N_OUT-1:0]     busy,
  output logic                 fault,
  output logic [7:0]           led_r,
  output logic [7:0]           led_g,
  output logic [7:0]           led_b
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_START = 3'd1,
    ST_IDLE  = 3'd2,
    ST_S1    = 3'd3,
    ST_S2    = 3'd4,
    ST_S3    = 3'd5
  } phase_state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
  localparam logic [1:0]       NO_REQ   = 2'd3;

  phase_state_t        state_r  [N_OUT];
  phase_state_t        state_nx_s [N_OUT];
  logic [CNT_W-1:0]    cnt_r    [N_OUT];
  logic [CNT_W-1:0]    cnt_nx_s [N_OUT];
  logic [1:0]          cur_r    [N_OUT];
  logic [1:0]          cur_nx_s [N_OUT];
  logic [1:0]          tgt_r    [N_OUT];
  logic [1:0]          tgt_nx_s [N_OUT];
  logic                d_r      [N_OUT];
  logic                d_nx_s   [N_OUT];
  logic                fault_r;
  logic [6*N_OUT-1:0]  gate_r;
  logic [N_OUT-1:0]    busy_r;

  // Gate bit of one device: input src, rev=0 forward, rev=1 reverse.
  function automatic logic [5:0] dev_mask(input logic [1:0] src, input logic rev);
    logic [5:0] m;
    m = 6'd0;
    case (src)
      2'd0:    m = rev ? 6'b000010 : 6'b000001;
      2'd1:    m = rev ? 6'b001000 : 6'b000100;
      2'd2:    m = rev ? 6'b100000 : 6'b010000;
      default: m = 6'd0;
    endcase
    return m;
  endfunction

  // Devices conducting in each state; d=1 uses forward devices, d=0 reverse.
  function automatic logic [5:0] phase_gates(input phase_state_t st, input logic [1:0] cur,
                                             input logic [1:0] tgt, input logic d);
    logic [5:0] g;
    g = 6'd0;
    case (st)
      ST_IDLE: g = dev_mask(cur, 1'b0) | dev_mask(cur, 1'b1);
      ST_S1:   g = dev_mask(cur, ~d);
      ST_S2:   g = dev_mask(cur, ~d) | dev_mask(tgt, ~d);
      ST_S3:   g = dev_mask(tgt, ~d);
      default: g = 6'd0;
    endcase
    return g;
  endfunction

  function automatic logic is_busy(input phase_state_t st);
    return (st == ST_START) || (st == ST_S1) || (st == ST_S2) || (st == ST_S3);
  endfunction

  // Clamp fault latch; a simultaneous clear never wins over a new clamp event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (clamp_signal) begin
      fault_r <= 1'b1;
    end else if (fault_clr) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r;
    end
  end

  // Per-phase FSM state, dwell counter and latched commutation context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_OUT; p++) begin
        state_r[p] <= ST_OFF;
        cnt_r[p]   <= ZERO_CNT;
        cur_r[p]   <= 2'd0;
        tgt_r[p]   <= 2'd0;
        d_r[p]     <= 1'b0;
      end
    end else begin
      for (int p = 0; p < N_OUT; p++) begin
        state_r[p] <= state_nx_s[p];
        cnt_r[p]   <= cnt_nx_s[p];
        cur_r[p]   <= cur_nx_s[p];
        tgt_r[p]   <= tgt_nx_s[p];
        d_r[p]     <= d_nx_s[p];
      end
    end
  end

  // Next-state logic; a latched fault overrides everything and parks phases in OFF.
  always_comb begin
    for (int p = 0; p < N_OUT; p++) begin
      state_nx_s[p] = state_r[p];
      cnt_nx_s[p]   = cnt_r[p];
      cur_nx_s[p]   = cur_r[p];
      tgt_nx_s[p]   = tgt_r[p];
      d_nx_s[p]     = d_r[p];
      if (fault_r) begin
        state_nx_s[p] = ST_OFF;
        cnt_nx_s[p]   = ZERO_CNT;
      end else begin
        case (state_r[p])
          ST_OFF: begin
            if (ce && (sel[2*p +: 2] != NO_REQ)) begin
              tgt_nx_s[p]   = sel[2*p +: 2];
              cnt_nx_s[p]   = ZERO_CNT;
              state_nx_s[p] = ST_START;
            end else begin
              cnt_nx_s[p]   = ZERO_CNT;
            end
          end
          ST_IDLE: begin
            if (ce && (sel[2*p +: 2] != NO_REQ) && (sel[2*p +: 2] != cur_r[p])) begin
              tgt_nx_s[p]   = sel[2*p +: 2];
              d_nx_s[p]     = dir[p];
              cnt_nx_s[p]   = ZERO_CNT;
              state_nx_s[p] = ST_S1;
            end else begin
              cnt_nx_s[p]   = ZERO_CNT;
            end
          end
          ST_START, ST_S1, ST_S2, ST_S3: begin
            if (!ce) begin
              cnt_nx_s[p] = cnt_r[p];
            end else if (cnt_r[p] != LAST_CNT) begin
              cnt_nx_s[p] = cnt_r[p] + ONE_CNT;
            end else begin
              cnt_nx_s[p] = ZERO_CNT;
              case (state_r[p])
                ST_START: begin
                  state_nx_s[p] = ST_IDLE;
                  cur_nx_s[p]   = tgt_r[p];
                end
                ST_S1:   state_nx_s[p] = ST_S2;
                ST_S2:   state_nx_s[p] = ST_S3;
                ST_S3: begin
                  state_nx_s[p] = ST_IDLE;
                  cur_nx_s[p]   = tgt_r[p];
                end
                default: state_nx_s[p] = ST_OFF;
              endcase
            end
          end
          default: begin
            state_nx_s[p] = ST_OFF;
            cnt_nx_s[p]   = ZERO_CNT;
          end
        endcase
      end
    end
  end

  // Registered gate and busy outputs, blanked on the edge after a fault latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r <= '0;
      busy_r <= '0;
    end else begin
      for (int p = 0; p < N_OUT; p++) begin
        gate_r[6*p +: 6] <= fault_r ? 6'd0 : phase_gates(state_r[p], cur_r[p], tgt_r[p], d_r[p]);
        busy_r[p]        <= ~fault_r & is_busy(state_r[p]);
      end
    end
  end

  assign gate  = gate_r;
  assign busy  = busy_r;
  assign fault = fault_r;

  assign led_r = fault_r ? 8'd255 : 8'd0;
  assign led_g = (!fault_r && (|busy_r)) ? 8'd255 : 8'd0;
  assign led_b = (!fault_r && (|busy_r)) ? 8'd255 : 8'd0;

endmodule

// File: tb/tb_matrix_commutator.sv
// Directed bench for matrix_commutator with STEP_CYCLES=4 and three phases.
// It ends with a random run that checks gate safety on every cycle.
module tb_matrix_commutator;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [5:0]  sel;
  logic [2:0]  dir;
  logic        clamp_signal;
  logic        fault_clr;
  logic [17:0] gate;
  logic [2:0]  busy;
  logic        fault;
  logic [7:0]  led_r, led_g, led_b;

  int vectors = 0;
  int errors  = 0;

  matrix_commutator #(.N_OUT(3), .STEP_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sel(sel), .dir(dir),
    .clamp_signal(clamp_signal), .fault_clr(fault_clr),
    .gate(gate), .busy(busy), .fault(fault),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Safe means no F_i with R_j (i != j) and never two inputs fully on.
  function automatic logic gates_safe(input logic [17:0] g);
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (i != j) begin
            if (g[6*p+2*i] && g[6*p+2*j+1]) ok = 1'b0;
            if (g[6*p+2*i] && g[6*p+2*i+1] && g[6*p+2*j] && g[6*p+2*j+1]) ok = 1'b0;
          end
    return ok;
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("no_shoot", 32'(gates_safe(gate)), 32'd1);
    end
  endtask

  logic [5:0] low;

  initial begin
    rst_n = 1'b0; ce = 1'b0; sel = 6'h3F; dir = 3'b000;
    clamp_signal = 1'b0; fault_clr = 1'b0;
    #3;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    step(2);
    check("rst_led", 32'({led_r, led_g, led_b}), 32'd0);

    // startup: all phases request input 0
    rst_n = 1'b1; sel = 6'b000000; ce = 1'b1;
    step(1);
    check("start_busy0", 32'(busy), 32'd0);
    check("start_gate0", 32'(gate), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("start_busy", 32'(busy), 32'd7);
      check("start_gate", 32'(gate), 32'd0);
      check("start_ledg", 32'(led_g), 32'd255);
    end
    step(1);
    check("idle_gate", 32'(gate), 32'h030C3);
    check("idle_busy", 32'(busy), 32'd0);

    // phase 0: input 0 -> 1 with forward current
    sel = 6'b000001; dir = 3'b001;
    step(1);
    check("fw_req_gate", 32'(gate), 32'h030C3);
    check("fw_req_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      low = (i < 4) ? 6'b000001 : ((i < 8) ? 6'b000101 : 6'b000100);
      check("fw_gate", 32'(gate), 32'({12'h0C3, low}));
      check("fw_busy", 32'(busy), 32'd1);
    end
    step(1);
    check("fw_done_gate", 32'(gate), 32'({12'h0C3, 6'b001100}));
    check("fw_done_busy", 32'(busy), 32'd0);

    // phase 0: input 1 -> 0 with reverse current; dir toggle mid-sequence ignored
    sel = 6'b000000; dir = 3'b000;
    step(1);
    check("rv_req_gate", 32'(gate), 32'({12'h0C3, 6'b001100}));
    for (int i = 0; i < 12; i++) begin
      step(1);
      low = (i < 4) ? 6'b001000 : ((i < 8) ? 6'b001010 : 6'b000010);
      check("rv_gate", 32'(gate), 32'({12'h0C3, low}));
      check("rv_busy", 32'(busy), 32'd1);
      if (i == 5) dir = 3'b111;
    end
    step(1);
    check("rv_done_gate", 32'(gate), 32'h030C3);
    check("rv_done_busy", 32'(busy), 32'd0);

    // sel = 3 and sel = cur are both ignored in IDLE
    sel = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("noreq_busy", 32'(busy), 32'd0);
      check("noreq_gate", 32'(gate), 32'h030C3);
    end
    sel = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("samesel_busy", 32'(busy), 32'd0);
      check("samesel_gate", 32'(gate), 32'h030C3);
    end

    // phase 0: 0 -> 2 forward, ce low for 10 cycles inside S1
    dir = 3'b001; sel = 6'b000010;
    step(1);
    check("ce_req_gate", 32'(gate), 32'h030C3);
    step(1);
    check("ce_s1_first", 32'(gate), 32'({12'h0C3, 6'b000001}));
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("ce_frozen_gate", 32'(gate), 32'({12'h0C3, 6'b000001}));
      check("ce_frozen_busy", 32'(busy), 32'd1);
    end
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ce_s1_tail", 32'(gate), 32'({12'h0C3, 6'b000001}));
    end
    step(1);
    check("ce_s2", 32'(gate), 32'({12'h0C3, 6'b010001}));

    // clamp pulse during S2
    clamp_signal = 1'b1;
    step(1);
    check("flt_set", 32'(fault), 32'd1);
    check("flt_gate_hold", 32'(gate), 32'({12'h0C3, 6'b010001}));
    check("flt_led", 32'({led_r, led_g, led_b}), 32'hFF0000);
    clamp_signal = 1'b0; sel = 6'b010101;
    step(1);
    check("flt_gate_off", 32'(gate), 32'd0);
    check("flt_busy_off", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("flt_hold_gate", 32'(gate), 32'd0);
      check("flt_hold_busy", 32'(busy), 32'd0);
      check("flt_hold", 32'(fault), 32'd1);
    end
    clamp_signal = 1'b1; fault_clr = 1'b1;
    step(1);
    check("flt_clr_blocked", 32'(fault), 32'd1);
    clamp_signal = 1'b0;
    step(1);
    check("flt_cleared", 32'(fault), 32'd0);
    check("flt_clr_led", 32'({led_r, led_g, led_b}), 32'd0);
    fault_clr = 1'b0;
    step(1);
    check("rest_gate0", 32'(gate), 32'd0);
    check("rest_busy0", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("rest_busy", 32'(busy), 32'd7);
      check("rest_gate", 32'(gate), 32'd0);
      check("rest_led", 32'({led_r, led_g, led_b}), 32'h00FFFF);
    end
    step(1);
    check("rest_idle_gate", 32'(gate), 32'h0C30C);
    check("rest_idle_busy", 32'(busy), 32'd0);

    // phase 1: 1 -> 0 forward, reset asserted in S2
    sel = 6'b010001; dir = 3'b111;
    step(6);
    check("mid_gate", 32'(gate), 32'h0C14C);
    check("mid_busy", 32'(busy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gate", 32'(gate), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_fault", 32'(fault), 32'd0);

    // random stress; step() checks gate safety every cycle
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ce           = ($urandom_range(0, 9) != 0);
      sel          = 6'($urandom_range(0, 63));
      dir          = 3'($urandom_range(0, 7));
      clamp_signal = ($urandom_range(0, 499) == 0);
      fault_clr    = ($urandom_range(0, 49) == 0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/matrix_commutator.md
Name: matrix_commutator

Overview:
- Parametrised successor to the fixed three-phase four-step commutation stage of the matrix-converter DMC/SVM path.
- Drives N_OUT output phases. Each phase has 3 bidirectional switches (forward/reverse device per switch), so 6 gates per phase.
- Runs current-direction-based four-step commutation from the system clock, using a programmable dwell counter instead of a derived slow clock.
- Adds a clearable clamp-fault latch, per-phase busy flags and a status LED drive.

Parameters:
- N_OUT, 3, number of output phases.
- STEP_CYCLES, 400, clk cycles each commutation step is held (4 us at 10 ns); must be ≥ 1.
- CNT_W, 16, dwell counter width; must satisfy 2^CNT_W > STEP_CYCLES.

Ports:
- clk  in  1  system clock, 10 ns.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  count/advance enable.
- sel  in  2*N_OUT  per-phase requested input source (0,1,2); value 3 means "no request".
- dir  in  N_OUT  per-phase load-current sign; 1 = forward device conducts.
- clamp_signal  in  1  clamp over-voltage fault, synchronous to clk.
- fault_clr  in  1  fault clear request, level.
- gate  out  6*N_OUT  phase p bits [6p+2k] = forward device of input k, [6p+2k+1] = reverse device of input k.
- busy  out  N_OUT  phase is mid-commutation or mid-startup.
- fault  out  1  latched fault.
- led_r, led_g, led_b  out  8 each  status LED.

Behaviour:
- Reset (async, rst_n=0):
  - Every phase enters OFF; gate=0, busy=0, fault=0, dwell counter=0.
  - Output is immediate, independent of clk.
- All registers update on posedge clk. gate, busy and fault are registered outputs.
- Per-phase FSM states: OFF, START, IDLE, S1, S2, S3.
- OFF:
  - gates of the phase = 0.
  - If sel_p ≠ 3 and ce=1: latch tgt ← sel_p, go to START.
- START:
  - gates = 0; busy=1.
  - After STEP_CYCLES counted cycles: cur ← tgt, go to IDLE.
- IDLE:
  - gates = {F_cur, R_cur}; busy=0.
  - If ce=1, sel_p ≠ 3 and sel_p ≠ cur: latch tgt ← sel_p and d ← dir_p, go to S1.
  - Sel values 3 or equal to cur are ignored.
- Step patterns for d=1 (registered, each held exactly STEP_CYCLES counted cycles):
  - S1 = {F_cur}
  - S2 = {F_cur, F_tgt}
  - S3 = {F_tgt}
  - then IDLE with cur ← tgt, giving {F_tgt, R_tgt}.
- For d=0, swap F and R throughout.
- Timing: request seen in IDLE at edge t gives S1 at t+1, S2 at t+1+S, S3 at t+1+2S and the new IDLE at t+1+3S (S = STEP_CYCLES, ce held 1). busy=1 from t+1 until t+1+3S.
- sel and dir changes during START/S1–S3 are ignored; sel is re-evaluated in the first IDLE cycle.
- Never allowed: two devices of different inputs conducting in opposite directions, or both devices of two inputs on simultaneously. Verification must assert this every cycle.
- ce=0 freezes the dwell counters, holds the FSM state and gates, and blocks new requests. Fault handling still operates.
- Fault latch:
  - clamp_signal=1 at an edge sets fault at that edge.
  - Next edge: gate=0 for all phases, all FSMs go to OFF, busy=0.
  - While fault=1, FSMs stay in OFF regardless of sel.
  - fault_clr=1 with clamp_signal=0 clears fault at that edge.
  - fault_clr and clamp_signal both 1: fault stays set.
  - After clear, phases restart via OFF→START (full dwell with gates off before conducting).
- LED drive (combinational from registers):
  - fault=1: r=255, g=0, b=0.
  - else: r=0, g=255, b=255 if any busy else 0.
- Reset asserted mid-commutation: gates go to 0 immediately; there is no completion of steps.

Test Plan:
1. STEP_CYCLES=4, N_OUT=3, rst_n released, sel=all 0, ce=1 → gate=0 for 4 cycles after START entry, then each phase gate[1:0]=2'b11; busy high exactly 4 cycles.
2. Phase 0 in IDLE cur=0, dir=1, sel_0→1 → gate[5:0] sequence 000001, 000101, 000100 (4 cycles each), then 001100; busy_0=1 for 12 cycles; phases 1,2 unchanged.
3. Same as 2 with dir=0 → 000010, 001010, 001000, then 001100. Toggling dir mid-sequence has no effect.
4. clamp_signal pulsed 1 cycle during S2 → fault=1 next edge; gate=0 the edge after; led_r=255, led_g=0. sel changes are ignored until cleared. fault_clr with clamp low clears fault; the START dwell of 4 cycles precedes any gate.
5. clamp_signal and fault_clr both 1 → fault remains 1. ce=0 during S1 for 10 cycles → S1 lasts 14 cycles total.
6. sel_p=3 or sel_p=cur in IDLE → no transition, busy stays 0. Randomised sel/dir run of 10k cycles → the shoot-through assertion never fires.
